conv_2d: RTL and testbench



---
 rtl/conv2d_pkg.sv | 40 ++++
 rtl/conv_2d_pe.sv | 72 +++++++
 rtl/conv_2d.sv | 92 +++++++++
 tb/tb_conv_2d.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// conv2d_pkg: layout index helpers and sizing functions for conv_2d.
// Shared by the top and the per-pixel processing element.
package conv2d_pkg;

  function automatic int in_idx(
    input int b, input int c, input int y, input int x,
    input int ic, input int h, input int w
  );
    return ((b * ic + c) * h + y) * w + x;
  endfunction

  function automatic int w_idx(
    input int o, input int c, input int ky, input int kx,
    input int ic, input int k
  );
    return ((o * ic + c) * k + ky) * k + kx;
  endfunction

  function automatic int out_idx(
    input int b, input int o, input int oy, input int ox,
    input int oc, input int oh, input int ow
  );
    return ((b * oc + o) * oh + oy) * ow + ox;
  endfunction

  // Guarded so a bad stride reports the parameter check, not a div-by-0.
  function automatic int out_size(
    input int n, input int k, input int s, input int p
  );
    if (s < 1) return 1;
    return (n + 2 * p - k) / s + 1;
  endfunction

  function automatic int acc_width(
    input int ic, input int k, input int dw
  );
    return 2 * dw + $clog2(ic * k * k + 1);
  endfunction

endpackage

// File: rtl/conv_2d_pe.sv
// conv_2d_pe: one output pixel as a signed MAC over IC*K*K taps.
// Reduction clamps when CONV2D_SATURATE_EN is defined, else wraps.
module conv_2d_pe
  import conv2d_pkg::*;
#(
  parameter int IC      = 2,
  parameter int H       = 4,
  parameter int W       = 4,
  parameter int K       = 2,
  parameter int STRIDE  = 2,
  parameter int PADDING = 0,
  parameter int DW      = 32,
  parameter int OY      = 0,
  parameter int OX      = 0
) (
  input  logic [IC*H*W*DW-1:0] img_i,
  input  logic [IC*K*K*DW-1:0] wgt_i,
  input  logic [DW-1:0]        bias_i,
  output logic [DW-1:0]        res_o
);

  localparam int AW = acc_width(IC, K, DW);
  localparam int PW = 2 * DW;

  localparam logic signed [AW-1:0] MAXV =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Accumulate bias plus every in-range tap, then reduce to DW bits.
  always_comb begin : mac
    logic signed [AW-1:0] acc;
    logic signed [PW-1:0] prod;
    logic signed [DW-1:0] px;
    logic signed [DW-1:0] wt;
    logic                 ok;
    int                   iy;
    int                   ix;
    int                   idx;
    acc  = AW'($signed(bias_i));
    prod = '0;
    px   = '0;
    wt   = '0;
    ok   = 1'b0;
    iy   = 0;
    ix   = 0;
    idx  = 0;
    for (int c = 0; c < IC; c++) begin
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          iy  = OY * STRIDE + ky - PADDING;
          ix  = OX * STRIDE + kx - PADDING;
          ok  = (iy >= 0) && (iy < H) &&
                (ix >= 0) && (ix < W);
          idx = ok ? in_idx(0, c, iy, ix, IC, H, W) : 0;
          px  = ok ? $signed(img_i[idx*DW +: DW]) : '0;
          wt  = $signed(wgt_i[w_idx(0, c, ky, kx, IC, K)*DW +: DW]);
          prod = px * wt;
          acc  = acc + AW'(prod);
        end
      end
    end
`ifdef CONV2D_SATURATE_EN
    if (acc > MAXV)      res_o = MAXV[DW-1:0];
    else if (acc < MINV) res_o = MINV[DW-1:0];
    else                 res_o = acc[DW-1:0];
`else
    res_o = acc[DW-1:0];
`endif
  end

endmodule

// File: rtl/conv_2d.sv
// conv_2d: fully parallel 2-D convolution, one tensor per clock.
// Optional CONV2D_SATURATE_EN clamps results instead of wrapping.
module conv_2d
  import conv2d_pkg::*;
#(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 32,
  localparam int OUT_HEIGHT =
    out_size(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING),
  localparam int OUT_WIDTH =
    out_size(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING)
) (
  input  logic clk,
  input  logic rst,
  input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]
               input_tensor_flat,
  input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]
               weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]
               bias_flat,
  output logic [BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH*DATA_WIDTH-1:0]
               output_tensor_flat
);

  localparam int DW   = DATA_WIDTH;
  localparam int IMG  = IN_CHANNELS * IN_HEIGHT * IN_WIDTH * DW;
  localparam int WSET = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE * DW;
  localparam int NOUT =
    BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH;

  if (KERNEL_SIZE > IN_HEIGHT + 2 * PADDING) begin : g_bad_h
    $error("conv_2d: KERNEL_SIZE exceeds padded height");
  end
  if (KERNEL_SIZE > IN_WIDTH + 2 * PADDING) begin : g_bad_w
    $error("conv_2d: KERNEL_SIZE exceeds padded width");
  end
  if (STRIDE < 1) begin : g_bad_s
    $error("conv_2d: STRIDE must be at least 1");
  end

  logic [NOUT*DW-1:0] pe_res;
  logic [NOUT*DW-1:0] out_d;
  logic [NOUT*DW-1:0] out_q;

  for (genvar b = 0; b < BATCH_SIZE; b++) begin : g_b
    for (genvar o = 0; o < OUT_CHANNELS; o++) begin : g_o
      for (genvar oy = 0; oy < OUT_HEIGHT; oy++) begin : g_y
        for (genvar ox = 0; ox < OUT_WIDTH; ox++) begin : g_x
          localparam int OI =
            out_idx(b, o, oy, ox, OUT_CHANNELS, OUT_HEIGHT, OUT_WIDTH);
          conv_2d_pe #(
            .IC      (IN_CHANNELS),
            .H       (IN_HEIGHT),
            .W       (IN_WIDTH),
            .K       (KERNEL_SIZE),
            .STRIDE  (STRIDE),
            .PADDING (PADDING),
            .DW      (DW),
            .OY      (oy),
            .OX      (ox)
          ) u_pe (
            .img_i  (input_tensor_flat[b*IMG +: IMG]),
            .wgt_i  (weights_flat[o*WSET +: WSET]),
            .bias_i (bias_flat[o*DW +: DW]),
            .res_o  (pe_res[OI*DW +: DW])
          );
        end
      end
    end
  end

  // Next output tensor is the full set of pixel results.
  always_comb begin
    out_d = pe_res;
  end

  // Output register; synchronous reset wins over the new result.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign output_tensor_flat = out_q;

endmodule

// File: tb/tb_conv_2d.sv
// tb_conv_2d: directed checks of conv_2d, default and padded configs.
// Expected values are hand-computed constants.
module tb_conv_2d;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [32*32-1:0] in_t  = '0;
  logic [8*32-1:0]  w_t   = '0;
  logic [31:0]      b_t   = '0;
  logic [4*32-1:0]  out_t;

  logic [16*32-1:0] pin_t;
  logic [9*32-1:0]  pw_t;
  logic [31:0]      pb_t;
  logic [16*32-1:0] pout_t;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_2d u_dut (
    .clk                (clk),
    .rst                (rst),
    .input_tensor_flat  (in_t),
    .weights_flat       (w_t),
    .bias_flat          (b_t),
    .output_tensor_flat (out_t)
  );

  conv_2d #(
    .IN_CHANNELS (1),
    .KERNEL_SIZE (3),
    .STRIDE      (1),
    .PADDING     (1)
  ) u_pad (
    .clk                (clk),
    .rst                (rst),
    .input_tensor_flat  (pin_t),
    .weights_flat       (pw_t),
    .bias_flat          (pb_t),
    .output_tensor_flat (pout_t)
  );

  task automatic check(
    input string tag, input logic [31:0] got, input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(
    input string tag,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic [31:0] e2, input logic [31:0] e3
  );
    check($sformatf("%s[0]", tag), out_t[0*32 +: 32], e0);
    check($sformatf("%s[1]", tag), out_t[1*32 +: 32], e1);
    check($sformatf("%s[2]", tag), out_t[2*32 +: 32], e2);
    check($sformatf("%s[3]", tag), out_t[3*32 +: 32], e3);
  endtask

  task automatic fill_w(input logic [31:0] v);
    for (int i = 0; i < 8; i++) w_t[i*32 +: 32] = v;
  endtask

  int pad_exp [16] = '{4, 6, 6, 4,
                       6, 9, 9, 6,
                       6, 9, 9, 6,
                       4, 6, 6, 4};

  logic [31:0] big_exp;

  initial begin
    for (int i = 0; i < 16; i++) pin_t[i*32 +: 32] = 32'd1;
    for (int i = 0; i < 9; i++)  pw_t[i*32 +: 32]  = 32'd1;
    pb_t = '0;
    for (int i = 0; i < 32; i++) in_t[i*32 +: 32] = 32'(i);
    fill_w(32'd1);
    b_t = 32'd7;

    // Reset with nonzero inputs present.
    tick();
    check4("reset", 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      check($sformatf("reset_pad[%0d]", i), pout_t[i*32 +: 32], 0);

    rst = 1'b0;
    b_t = '0;
    tick();
    check4("ramp_w1", 84, 100, 148, 164);
    for (int i = 0; i < 16; i++)
      check($sformatf("pad[%0d]", i), pout_t[i*32 +: 32],
            32'(pad_exp[i]));

    // New bias must not show until the next edge.
    b_t = 32'd5;
    #3;
    check("hold", out_t[0 +: 32], 84);
    tick();
    check4("bias5", 89, 105, 153, 169);

    fill_w(32'hFFFF_FFFF);
    b_t = '0;
    tick();
    check4("w_neg", -84, -100, -148, -164);

    // Mid-stream reset, then immediate recovery.
    rst = 1'b1;
    tick();
    check4("mid_rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check4("post_rst", -84, -100, -148, -164);

    // Overflow: 8 taps of 0x7FFFFFFF*2 = 2^35-16.
    for (int i = 0; i < 32; i++) in_t[i*32 +: 32] = 32'h7FFF_FFFF;
    fill_w(32'd2);
`ifdef CONV2D_SATURATE_EN
    big_exp = 32'h7FFF_FFFF;
`else
    big_exp = 32'hFFFF_FFF0;
`endif
    tick();
    check4("ovf", big_exp, big_exp, big_exp, big_exp);

    // Negative overflow, low bits of -(2^35-16) = 0x00000010.
    fill_w(32'hFFFF_FFFE);
`ifdef CONV2D_SATURATE_EN
    big_exp = 32'h8000_0000;
`else
    big_exp = 32'h0000_0010;
`endif
    tick();
    check4("ovf_neg", big_exp, big_exp, big_exp, big_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
